// File: rtl/output_op_collector_if.sv
// Result stream from an OutputOp into the collector.
// Producer drives data/valid, collector answers with ready.
interface output_op_collector_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/output_op_collector.sv
// Sink for the OutputOp stream: FWFT FIFO, run counter, completion flag.
// Optional checksum output when OUTPUT_OP_COLLECTOR_CHECKSUM_EN is defined.
module output_op_collector #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [CNT_W-1:0]     expected_count,
  output_op_collector_if.slave in_if,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  output logic [LW-1:0]        fifo_level,
  output logic [CNT_W-1:0]     accepted,
  output logic                 busy,
  output logic                 done
`ifdef OUTPUT_OP_COLLECTOR_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]     checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  state_e           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] cs_q, cs_d;

  logic [AW:0] level;
  logic        full;
  logic        empty;
  logic        ready;
  logic        push;
  logic        pop;
  logic        restart;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == FULL_LVL);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign ready   = (state_q == S_COLLECT) && !full && (acc_q != exp_q);
  assign push    = in_if.in_valid && ready;
  assign pop     = rd_en && !empty;
  assign restart = start && (state_q == S_IDLE || state_q == S_DONE);

  assign in_if.in_ready = ready;
  assign rd_valid       = !empty;
  assign rd_data        = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_level     = LW'(level);
  assign accepted       = acc_q;
  assign busy           = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);

`ifdef OUTPUT_OP_COLLECTOR_CHECKSUM_EN
  assign checksum = cs_q;
`endif

  // Next-state: run control, FIFO pointers, counters and checksum
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    acc_d    = acc_q;
    exp_d    = exp_q;
    mem_d    = mem_q;
    cs_d     = cs_q;
    if (restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      acc_d    = '0;
      cs_d     = '0;
      exp_d    = expected_count;
      state_d  = (expected_count == '0) ? S_DONE : S_COLLECT;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = in_if.in_data;
        wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        acc_d    = acc_q + CNT_W'(1);
        cs_d     = ((cs_q << 1) | (cs_q >> (WIDTH - 1)))
                   ^ in_if.in_data;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      end
      unique case (state_q)
        S_COLLECT: if (acc_d == exp_q) state_d = S_DRAIN;
        S_DRAIN:   if (wr_ptr_d == rd_ptr_d) state_d = S_DONE;
        default:   ;
      endcase
    end
  end

  // State registers; reset discards buffered data
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      acc_q    <= '0;
      exp_q    <= '0;
      mem_q    <= '{default: '0};
      cs_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      acc_q    <= acc_d;
      exp_q    <= exp_d;
      mem_q    <= mem_d;
      cs_q     <= cs_d;
    end
  end

endmodule

// File: tb/tb_output_op_collector.sv
// Directed bench for output_op_collector with a queue-based reference model.
// Checksum checks are compiled only with OUTPUT_OP_COLLECTOR_CHECKSUM_EN.
module tb_output_op_collector;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = 16;

  localparam int P_IDLE  = 0;
  localparam int P_COL   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          start;
  logic [CW-1:0] expected_count;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic [3:0]    fifo_level;
  logic [CW-1:0] accepted;
  logic          busy;
  logic          done;
`ifdef OUTPUT_OP_COLLECTOR_CHECKSUM_EN
  logic [W-1:0]  checksum;
`endif

  output_op_collector_if #(.WIDTH(W)) in_if ();

  output_op_collector #(
    .WIDTH(W),
    .DEPTH(D),
    .CNT_W(CW)
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .start         (start),
    .expected_count(expected_count),
    .in_if         (in_if),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .fifo_level    (fifo_level),
    .accepted      (accepted),
    .busy          (busy),
    .done          (done)
`ifdef OUTPUT_OP_COLLECTOR_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: results queue, run counters, run phase
  logic [7:0] mq[$];
  int         m_acc;
  int         m_exp;
  int         m_ph;
  logic [7:0] m_cs;

  function automatic bit m_ready();
    return (m_ph == P_COL) && (mq.size() < D) && (m_acc != m_exp);
  endfunction

  always @(posedge CLK or negedge resetn) begin : model
    bit push;
    bit pop;
    if (!resetn) begin
      mq.delete();
      m_acc = 0;
      m_exp = 0;
      m_ph  = P_IDLE;
      m_cs  = 8'h00;
    end else begin
      push = m_ready() && in_if.in_valid;
      pop  = rd_en && (mq.size() > 0);
      if (start && (m_ph == P_IDLE || m_ph == P_DONE)) begin
        mq.delete();
        m_acc = 0;
        m_cs  = 8'h00;
        m_exp = int'(expected_count);
        m_ph  = (m_exp == 0) ? P_DONE : P_COL;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(in_if.in_data);
          m_acc++;
          m_cs = {m_cs[6:0], m_cs[7]} ^ in_if.in_data;
        end
        if (m_ph == P_COL && m_acc == m_exp) m_ph = P_DRAIN;
        else if (m_ph == P_DRAIN && mq.size() == 0) m_ph = P_DONE;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("m_in_ready", in_if.in_ready, m_ready());
      chk("m_rd_valid", rd_valid, mq.size() > 0);
      chk("m_rd_data", rd_data, (mq.size() > 0) ? mq[0] : 8'h00);
      chk("m_level", fifo_level, mq.size());
      chk("m_accepted", accepted, m_acc);
      chk("m_busy", busy, (m_ph == P_COL) || (m_ph == P_DRAIN));
      chk("m_done", done, m_ph == P_DONE);
`ifdef OUTPUT_OP_COLLECTOR_CHECKSUM_EN
      chk("m_checksum", checksum, m_cs);
`endif
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(int n);
    start = 1'b1;
    expected_count = CW'(n);
    step();
    start = 1'b0;
  endtask

  task automatic pop_until_done(string name);
    int g;
    g = 0;
    rd_en = 1'b1;
    while (!done && g < 40) begin
      step();
      g++;
    end
    rd_en = 1'b0;
    chk(name, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [3];
    logic       rdy;
    int         n;
    int         g;
    t1 = '{8'h11, 8'h22, 8'h33};
    resetn = 1'b0;
    start = 1'b0;
    expected_count = '0;
    rd_en = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data = '0;
    repeat (2) step();
    chk_on = 1;
    chk("rst_level", fifo_level, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_if.in_ready, 0);
    chk("rst_rd_data", rd_data, 0);
    resetn = 1'b1;
    step();

    // three words, no reads, then drain
    do_start(3);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_if.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      in_if.in_valid = 1'b1;
      in_if.in_data = t1[i];
      step();
    end
    in_if.in_valid = 1'b0;
    chk("t1_acc", accepted, 3);
    chk("t1_level", fifo_level, 3);
    chk("t1_ready_off", in_if.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_rd", rd_data, t1[i]);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    chk("t1_done", done, 1);
    chk("t1_rd_valid", rd_valid, 0);

    // fill to full with valid held high
    do_start(12);
    n = 0;
    g = 0;
    in_if.in_valid = 1'b1;
    in_if.in_data = 8'hA0;
    while (n < 8 && g < 50) begin
      rdy = in_if.in_ready;
      step();
      g++;
      if (rdy) begin
        n++;
        in_if.in_data = 8'(8'hA0 + n);
      end
    end
    chk("t2_fill_bound", g < 50, 1);
    chk("t2_level", fifo_level, 8);
    chk("t2_ready", in_if.in_ready, 0);
    step();
    chk("t2_level_hold", fifo_level, 8);
    chk("t2_acc_hold", accepted, 8);

    // pop and valid together while full
    chk("t3_head", rd_data, 8'hA0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t3_level", fifo_level, 7);
    chk("t3_ready", in_if.in_ready, 1);
    chk("t3_acc", accepted, 8);
    step();
    n++;
    in_if.in_data = 8'(8'hA0 + n);
    chk("t3_push", fifo_level, 8);
    chk("t3_acc2", accepted, 9);
    rd_en = 1'b1;
    g = 0;
    while (!done && g < 60) begin
      rdy = in_if.in_ready && in_if.in_valid;
      step();
      g++;
      if (rdy) begin
        n++;
        in_if.in_data = 8'(8'hA0 + n);
        if (n == 12) in_if.in_valid = 1'b0;
      end
    end
    rd_en = 1'b0;
    in_if.in_valid = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_acc_final", accepted, 12);
    chk("t3_level_final", fifo_level, 0);

    // zero-length run
    do_start(0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    in_if.in_valid = 1'b1;
    in_if.in_data = 8'h5A;
    repeat (3) begin
      chk("t4_ready", in_if.in_ready, 0);
      step();
    end
    in_if.in_valid = 1'b0;
    chk("t4_acc", accepted, 0);

    // reset mid-run, then a clean restart
    do_start(5);
    in_if.in_valid = 1'b1;
    in_if.in_data = 8'h55;
    step();
    in_if.in_data = 8'h66;
    step();
    in_if.in_valid = 1'b0;
    chk("t5_acc_pre", accepted, 2);
    resetn = 1'b0;
    #1;
    chk("t5_acc", accepted, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_rd_data", rd_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_ready", in_if.in_ready, 0);
    step();
    resetn = 1'b1;
    step();
    do_start(5);
    in_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_if.in_data = 8'(8'hC0 + i);
      step();
    end
    in_if.in_valid = 1'b0;
    chk("t5_acc_run", accepted, 5);
    chk("t5_head", rd_data, 8'hC0);
    pop_until_done("t5_done_run");

`ifdef OUTPUT_OP_COLLECTOR_CHECKSUM_EN
    do_start(2);
    chk("t6_cs_clear", checksum, 8'h00);
    in_if.in_valid = 1'b1;
    in_if.in_data = 8'h01;
    step();
    in_if.in_data = 8'h80;
    step();
    in_if.in_valid = 1'b0;
    chk("t6_cs", checksum, 8'h82);
    pop_until_done("t6_done");
    chk("t6_cs_stable", checksum, 8'h82);
`endif

    step();
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
